// File: rtl/keypad_debouncer_pkg.sv
// Shared types and constants for the keypad debounce stage.
// Holds the FSM encoding, the hex key map and default window lengths.
package keypad_debouncer_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } kd_state_e;

   localparam int DEF_DEBOUNCE_CYCLES = 60000;
   localparam int DEF_RELEASE_CYCLES  = 30000;

   localparam logic [3:0] KEY_0 = 4'h0;
   localparam logic [3:0] KEY_1 = 4'h1;
   localparam logic [3:0] KEY_2 = 4'h2;
   localparam logic [3:0] KEY_3 = 4'h3;
   localparam logic [3:0] KEY_4 = 4'h4;
   localparam logic [3:0] KEY_5 = 4'h5;
   localparam logic [3:0] KEY_6 = 4'h6;
   localparam logic [3:0] KEY_7 = 4'h7;
   localparam logic [3:0] KEY_8 = 4'h8;
   localparam logic [3:0] KEY_9 = 4'h9;
   localparam logic [3:0] KEY_A = 4'hA;
   localparam logic [3:0] KEY_B = 4'hB;
   localparam logic [3:0] KEY_C = 4'hC;
   localparam logic [3:0] KEY_D = 4'hD;
   localparam logic [3:0] KEY_E = 4'hE;
   localparam logic [3:0] KEY_F = 4'hF;

   // Position of the set bit; callers qualify one-hotness separately.
   function automatic logic [1:0] onehot_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      case (1'b1)
         v[0]:    idx = 2'd0;
         v[1]:    idx = 2'd1;
         v[2]:    idx = 2'd2;
         v[3]:    idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/keypad_debouncer_if.sv
// Scanner <-> debouncer bundle.
// master: scanner side, slave: debouncer side.
interface keypad_debouncer_if;

   logic       key_pressed;
   logic [3:0] row_idx;
   logic [3:0] col_idx;
   logic       key_valid;
   logic       new_key;
   logic [3:0] key_code;
   logic       key_held;

   modport master (
      output key_pressed,
      output row_idx,
      output col_idx,
      input  key_valid,
      input  new_key,
      input  key_code,
      input  key_held
   );

   modport slave (
      input  key_pressed,
      input  row_idx,
      input  col_idx,
      output key_valid,
      output new_key,
      output key_code,
      output key_held
   );

endinterface

// File: rtl/keypad_debouncer_decode.sv
// One-hot row/col to hex key code.
// Flags inputs that are not one-hot (idle or ghosting).
module keypad_decode
   import keypad_debouncer_pkg::*;
(
   input  logic [3:0] row_idx,
   input  logic [3:0] col_idx,
   output logic [3:0] code,
   output logic       invalid
);

   logic [1:0] r;
   logic [1:0] c;

   // Map (row, col) position onto the physical keypad legend.
   always_comb begin
      r       = onehot_idx(row_idx);
      c       = onehot_idx(col_idx);
      invalid = !($onehot(row_idx) && $onehot(col_idx));
      code    = KEY_0;
      case ({r, c})
         4'h0: code = KEY_1;
         4'h1: code = KEY_2;
         4'h2: code = KEY_3;
         4'h3: code = KEY_A;
         4'h4: code = KEY_4;
         4'h5: code = KEY_5;
         4'h6: code = KEY_6;
         4'h7: code = KEY_B;
         4'h8: code = KEY_7;
         4'h9: code = KEY_8;
         4'hA: code = KEY_9;
         4'hB: code = KEY_C;
         4'hC: code = KEY_E;
         4'hD: code = KEY_0;
         4'hE: code = KEY_F;
         4'hF: code = KEY_D;
         default: code = KEY_0;
      endcase
   end

endmodule

// File: rtl/keypad_debouncer.sv
// Debounce/decode stage after the keypad row scanner.
// One physical press yields exactly one new_key strobe.
module keypad_debouncer
   import keypad_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int RELEASE_CYCLES  = DEF_RELEASE_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   keypad_debouncer_if.slave  kif
);

   localparam int MAXC = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ?
                         DEBOUNCE_CYCLES : RELEASE_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   kd_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0]    row_q, row_d;
   logic [3:0]    col_q, col_d;
   logic [3:0]    code_q, code_d;
   logic          kp_q;
   logic          kv_q, kv_d;
   logic          nk_q, nk_d;
   logic [3:0]    kc_q, kc_d;
   logic          kh_q, kh_d;

   logic [3:0]    dec_code;
   logic          dec_invalid;
   logic          valid;
   logic          match;

   keypad_decode u_decode (
      .row_idx (kif.row_idx),
      .col_idx (kif.col_idx),
      .code    (dec_code),
      .invalid (dec_invalid)
   );

   assign valid   = kif.key_pressed && !dec_invalid;
   assign match   = valid && (kif.row_idx == row_q)
                          && (kif.col_idx == col_q);
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   // Next state, counter and registered outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      col_d   = col_q;
      code_d  = code_q;
      kv_d    = 1'b0;
      nk_d    = 1'b0;
      kc_d    = kc_q;
      kh_d    = kh_q;
      unique case (state_q)
         IDLE: begin
            if (valid) begin
               row_d   = kif.row_idx;
               col_d   = kif.col_idx;
               code_d  = dec_code;
               cnt_d   = '0;
               state_d = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (match && cnt_q == DEB_LAST) begin
               kv_d    = 1'b1;
               nk_d    = 1'b1;
               kc_d    = code_q;
               kh_d    = 1'b1;
               cnt_d   = '0;
               state_d = HELD;
            end else if (match) begin
               cnt_d   = cnt_inc;
            end else begin
               kv_d    = 1'b1;
               state_d = IDLE;
            end
         end
         HELD: begin
            // Only the first of back-to-back pressed samples pulses.
            kv_d = kif.key_pressed && !kp_q;
            if (match) begin
               cnt_d   = '0;
            end else if (cnt_q == REL_LAST) begin
               kh_d    = 1'b0;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         code_q  <= '0;
         kp_q    <= 1'b0;
         kv_q    <= 1'b0;
         nk_q    <= 1'b0;
         kc_q    <= '0;
         kh_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         col_q   <= col_d;
         code_q  <= code_d;
         kp_q    <= kif.key_pressed;
         kv_q    <= kv_d;
         nk_q    <= nk_d;
         kc_q    <= kc_d;
         kh_q    <= kh_d;
      end
   end

   assign kif.key_valid = kv_q;
   assign kif.new_key   = nk_q;
   assign kif.key_code  = kc_q;
   assign kif.key_held  = kh_q;

endmodule

// File: tb/tb_keypad_debouncer.sv
// Directed bench for keypad_debouncer (DEBOUNCE=8, RELEASE=12).
// Expected key codes are queued at press time, popped on new_key.
module tb_keypad_debouncer;
   import keypad_debouncer_pkg::*;

   localparam int DEB = 8;
   localparam int REL = 12;

   logic       clk = 1'b0;
   logic       rst;
   int         n_assert = 0;
   int         n_fail   = 0;
   logic [3:0] exp_q[$];
   logic [3:0] exp_code;

   keypad_debouncer_if kif();

   keypad_debouncer #(
      .DEBOUNCE_CYCLES (DEB),
      .RELEASE_CYCLES  (REL)
   ) dut (
      .clk (clk),
      .rst (rst),
      .kif (kif.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic kp,
                        input logic [3:0] r,
                        input logic [3:0] c);
      kif.key_pressed = kp;
      kif.row_idx     = r;
      kif.col_idx     = c;
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Scoreboard: every strobe must match the oldest queued code.
   always @(negedge clk) begin
      if (rst === 1'b0 && kif.new_key === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 8'(kif.new_key), 8'd0);
         end else begin
            exp_code = exp_q.pop_front();
            chk("strobe_code", 8'(kif.key_code), 8'(exp_code));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a valid key on the bus.
      rst = 1'b1;
      drive(1'b1, 4'b0001, 4'b0001);
      tick(3);
      chk("rst_new_key", 8'(kif.new_key), 8'd0);
      chk("rst_key_valid", 8'(kif.key_valid), 8'd0);
      chk("rst_key_code", 8'(kif.key_code), 8'd0);
      chk("rst_key_held", 8'(kif.key_held), 8'd0);
      chk("rst_state", 8'(dut.state_q), 8'(IDLE));
      rst = 1'b0;
      drive(1'b0, 4'b0000, 4'b0000);
      for (int i = 0; i < DEB; i++) begin
         tick(1);
         chk("post_rst_quiet", 8'(kif.new_key), 8'd0);
      end

      // Clean press of '6' (r1, c2).
      exp_q.push_back(KEY_6);
      drive(1'b1, 4'b0010, 4'b0100);
      for (int i = 0; i < DEB; i++) begin
         tick(1);
         chk("clean_no_early", 8'(kif.new_key), 8'd0);
         chk("clean_kv_early", 8'(kif.key_valid), 8'd0);
      end
      tick(1);
      chk("clean_new_key", 8'(kif.new_key), 8'd1);
      chk("clean_key_valid", 8'(kif.key_valid), 8'd1);
      chk("clean_key_code", 8'(kif.key_code), 8'h6);
      chk("clean_key_held", 8'(kif.key_held), 8'd1);
      drive(1'b0, 4'b0000, 4'b0000);
      tick(1);
      chk("clean_nk_1cyc", 8'(kif.new_key), 8'd0);
      chk("clean_kv_1cyc", 8'(kif.key_valid), 8'd0);
      tick(REL - 2);
      chk("clean_still_held", 8'(kif.key_held), 8'd1);
      tick(1);
      chk("clean_released", 8'(kif.key_held), 8'd0);
      chk("clean_rel_state", 8'(dut.state_q), 8'(IDLE));

      // Bounce: '5' drops at debounce cycle 4.
      drive(1'b1, 4'b0010, 4'b0010);
      tick(1);
      chk("bounce_in_deb", 8'(dut.state_q), 8'(DEBOUNCE));
      tick(3);
      drive(1'b0, 4'b0000, 4'b0000);
      tick(1);
      chk("bounce_kv", 8'(kif.key_valid), 8'd1);
      chk("bounce_nk", 8'(kif.new_key), 8'd0);
      chk("bounce_code", 8'(kif.key_code), 8'h6);
      chk("bounce_state", 8'(dut.state_q), 8'(IDLE));
      tick(1);
      chk("bounce_kv_end", 8'(kif.key_valid), 8'd0);

      // Accept 'D' (r3, c3), then intermittent matches.
      exp_q.push_back(KEY_D);
      drive(1'b1, 4'b1000, 4'b1000);
      tick(DEB + 1);
      chk("d_new_key", 8'(kif.new_key), 8'd1);
      chk("d_code", 8'(kif.key_code), 8'hD);
      drive(1'b0, 4'b0000, 4'b0000);
      tick(3);
      chk("d_gap_kv", 8'(kif.key_valid), 8'd0);
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 4'b1000, 4'b1000);
         tick(1);
         chk("held_kv", 8'(kif.key_valid), 8'd1);
         chk("held_hold", 8'(kif.key_held), 8'd1);
         drive(1'b0, 4'b0000, 4'b0000);
         tick(1);
         chk("held_kv_low", 8'(kif.key_valid), 8'd0);
         tick(2);
         chk("held_gap", 8'(kif.key_held), 8'd1);
      end
      for (int i = 0; i < REL - 4; i++) begin
         tick(1);
         chk("d_tail_held", 8'(kif.key_held), 8'd1);
      end
      tick(1);
      chk("d_released", 8'(kif.key_held), 8'd0);
      chk("d_rel_state", 8'(dut.state_q), 8'(IDLE));

      // Second key '1' while 'A' is held.
      exp_q.push_back(KEY_A);
      drive(1'b1, 4'b0001, 4'b1000);
      tick(DEB + 1);
      chk("a_code", 8'(kif.key_code), 8'hA);
      drive(1'b0, 4'b0000, 4'b0000);
      tick(1);
      chk("a_kv_low", 8'(kif.key_valid), 8'd0);
      drive(1'b1, 4'b0001, 4'b0001);
      tick(1);
      chk("two_kv", 8'(kif.key_valid), 8'd1);
      chk("two_nk", 8'(kif.new_key), 8'd0);
      chk("two_code", 8'(kif.key_code), 8'hA);
      chk("two_held", 8'(kif.key_held), 8'd1);
      tick(1);
      chk("two_kv_once", 8'(kif.key_valid), 8'd0);
      drive(1'b0, 4'b0000, 4'b0000);
      tick(1);
      tick(REL - 5);
      chk("two_still_held", 8'(kif.key_held), 8'd1);
      tick(1);
      chk("two_released", 8'(kif.key_held), 8'd0);

      // Ghosting and non one-hot rows stay idle.
      drive(1'b1, 4'b0100, 4'b0000);
      tick(3);
      chk("ghost_state", 8'(dut.state_q), 8'(IDLE));
      chk("ghost_kv", 8'(kif.key_valid), 8'd0);
      drive(1'b1, 4'b0011, 4'b0001);
      tick(1);
      chk("row2_state", 8'(dut.state_q), 8'(IDLE));

      // Reset at debounce cycle 5, then a fresh full window.
      drive(1'b1, 4'b0100, 4'b0010);
      tick(5);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_state", 8'(dut.state_q), 8'(IDLE));
      chk("mid_rst_cnt", 8'(dut.cnt_q), 8'd0);
      chk("mid_rst_code", 8'(kif.key_code), 8'd0);
      chk("mid_rst_nk", 8'(kif.new_key), 8'd0);
      chk("mid_rst_kv", 8'(kif.key_valid), 8'd0);
      tick(1);
      rst = 1'b0;
      exp_q.push_back(KEY_8);
      for (int i = 0; i < DEB; i++) begin
         tick(1);
         chk("after_rst_quiet", 8'(kif.new_key), 8'd0);
      end
      tick(1);
      chk("after_rst_nk", 8'(kif.new_key), 8'd1);
      chk("after_rst_code", 8'(kif.key_code), 8'h8);
      drive(1'b0, 4'b0000, 4'b0000);
      tick(REL + 1);
      chk("final_held", 8'(kif.key_held), 8'd0);
      chk("queue_empty", 8'(exp_q.size()), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
